// File: rtl/key_scheduler.sv
// key_scheduler: keyboard front end for the piano. Synchronises and debounces
// the 13 keys plus the two octave buttons, arbitrates ownership of the single
// tone generator (newest press wins), tracks the active scale, and serialises
// press/release events onto a ready/valid FIFO write port.
module key_scheduler #(
  parameter int unsigned SAMPLE_DIV = 50000,
  parameter int unsigned SCALE_MIN  = 1,
  parameter int unsigned SCALE_MAX  = 5
) (
  input  logic        clk,
  input  logic        reset_n,   // active-high despite the name: 1 = reset
  input  logic [12:0] KEYBOARD,
  input  logic        oct_up,
  input  logic        oct_dn,
  output logic        note_on,
  output logic [3:0]  note_idx,
  output logic [2:0]  scale,
  output logic        ivalid,
  output logic [9:0]  idata,
  input  logic        iready
);

  localparam int unsigned CntW    = $clog2(SAMPLE_DIV);
  localparam int          NumKeys = 13;

  typedef enum logic [1:0] {StIdle, StPick, StSend} ev_state_e;

  // Raw input bundle: [12:0] keys, [13] oct_up, [14] oct_dn.
  logic [14:0] sync1_q, sync2_q;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick;

  logic [14:0] samp_q, held_q, held_d;
  logic [14:0] agree, rise, fall;
  logic [12:0] key_rise, key_fall, key_held_d;

  logic       owner_on_q, owner_on_d;
  logic [3:0] owner_idx_q, owner_idx_d;

  logic [2:0] scale_q, scale_d;

  logic [12:0] pend_press_q, pend_press_d;
  logic [12:0] pend_rel_q, pend_rel_d;
  logic [12:0] pend_any;
  logic [12:0] press_clr, rel_clr;

  ev_state_e  state_q, state_d;
  logic [3:0] rr_q, rr_d;
  logic [9:0] idata_q, idata_d;
  logic [3:0] pick_key;
  logic       pick_press;

  // Two-flop synchroniser on every raw input.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {oct_dn, oct_up, KEYBOARD};
      sync2_q <= sync1_q;
    end
  end

  // Sample divider: wraps at SAMPLE_DIV-1 and ticks on the terminal count.
  always_comb begin
    tick  = (cnt_q == CntW'(SAMPLE_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Sample counter register.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A level is accepted only when this tick's sample matches the previous one.
  always_comb begin
    agree      = ~(sync2_q ^ samp_q);
    held_d     = tick ? ((agree & sync2_q) | (~agree & held_q)) : held_q;
    rise       = held_d & ~held_q;
    fall       = ~held_d & held_q;
    key_rise   = rise[12:0];
    key_fall   = fall[12:0];
    key_held_d = held_d[12:0];
  end

  // Debounce state: previous tick sample and the accepted stable level.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      samp_q <= '0;
      held_q <= '0;
    end else begin
      if (tick) begin
        samp_q <= sync2_q;
      end
      held_q <= held_d;
    end
  end

  // Owner arbitration: newest press wins (lowest index on a tie); losing the
  // owner hands the tone to the lowest key still held.
  always_comb begin
    owner_on_d  = owner_on_q;
    owner_idx_d = owner_idx_q;
    if (|key_rise) begin
      owner_on_d = 1'b1;
      for (int k = NumKeys - 1; k >= 0; k--) begin
        if (key_rise[k]) begin
          owner_idx_d = 4'(k);
        end
      end
    end else if (owner_on_q && key_fall[owner_idx_q]) begin
      owner_on_d  = 1'b0;
      owner_idx_d = '0;
      for (int k = NumKeys - 1; k >= 0; k--) begin
        if (key_held_d[k]) begin
          owner_on_d  = 1'b1;
          owner_idx_d = 4'(k);
        end
      end
    end
  end

  // Owner registers; only change on ticks because edges only exist on ticks.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      owner_on_q  <= 1'b0;
      owner_idx_q <= '0;
    end else begin
      owner_on_q  <= owner_on_d;
      owner_idx_q <= owner_idx_d;
    end
  end

  // Scale stepping with saturation; simultaneous up and down cancel.
  always_comb begin
    scale_d = scale_q;
    if (rise[13] && !rise[14]) begin
      if (scale_q < 3'(SCALE_MAX)) begin
        scale_d = scale_q + 3'd1;
      end
    end else if (rise[14] && !rise[13]) begin
      if (scale_q > 3'(SCALE_MIN)) begin
        scale_d = scale_q - 3'd1;
      end
    end
  end

  // Scale register.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      scale_q <= 3'(SCALE_MIN);
    end else begin
      scale_q <= scale_d;
    end
  end

  // Round-robin search: first key with any pending bit after rr_q. Iterating
  // from the far end lets the nearest candidate overwrite the others.
  always_comb begin
    logic [4:0] sum;
    sum      = '0;
    pend_any = pend_press_q | pend_rel_q;
    pick_key = rr_q;
    for (int i = NumKeys; i >= 1; i--) begin
      sum = {1'b0, rr_q} + 5'(i);
      if (sum >= 5'(NumKeys)) begin
        sum = sum - 5'(NumKeys);
      end
      if (pend_any[sum[3:0]]) begin
        pick_key = sum[3:0];
      end
    end
    pick_press = pend_press_q[pick_key];
  end

  // Event FSM next state and PICK actions.
  always_comb begin
    state_d   = state_q;
    idata_d   = idata_q;
    rr_d      = rr_q;
    press_clr = '0;
    rel_clr   = '0;
    unique case (state_q)
      StIdle: begin
        if (|pend_any) begin
          state_d = StPick;
        end
      end
      StPick: begin
        state_d = StSend;
        if (pick_press) begin
          press_clr[pick_key] = 1'b1;
          idata_d             = {1'b1, scale_q, pick_key, 2'b00};
          // Keep the pointer before this key so its release goes out next.
          if (!pend_rel_q[pick_key]) begin
            rr_d = pick_key;
          end
        end else begin
          rel_clr[pick_key] = 1'b1;
          idata_d           = {1'b0, scale_q, pick_key, 2'b00};
          rr_d              = pick_key;
        end
      end
      StSend: begin
        if (iready) begin
          state_d = (|pend_any) ? StPick : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pending bits saturate; a new edge wins over a same-cycle clear.
  always_comb begin
    pend_press_d = (pend_press_q & ~press_clr) | key_rise;
    pend_rel_d   = (pend_rel_q & ~rel_clr) | key_fall;
  end

  // Event FSM, pending bits, round-robin pointer and outgoing word.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q      <= StIdle;
      rr_q         <= 4'd12;
      idata_q      <= '0;
      pend_press_q <= '0;
      pend_rel_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      idata_q      <= idata_d;
      pend_press_q <= pend_press_d;
      pend_rel_q   <= pend_rel_d;
    end
  end

  // ivalid decodes straight from the state so reset drops it immediately.
  always_comb begin
    note_on  = owner_on_q;
    note_idx = owner_idx_q;
    scale    = scale_q;
    ivalid   = (state_q == StSend);
    idata    = idata_q;
  end

endmodule

// File: tb/tb_key_scheduler.sv
// Directed bench for key_scheduler with a short sample divider.
module tb_key_scheduler;

  localparam int SampleDiv = 4;
  localparam int Settle    = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [12:0] keyboard;
  logic        oct_up;
  logic        oct_dn;
  logic        note_on;
  logic [3:0]  note_idx;
  logic [2:0]  scale;
  logic        ivalid;
  logic [9:0]  idata;
  logic        iready;

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0] got_q[$];
  logic       prev_hold = 1'b0;
  logic [9:0] prev_data = '0;

  key_scheduler #(
    .SAMPLE_DIV(SampleDiv),
    .SCALE_MIN (1),
    .SCALE_MAX (5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .KEYBOARD(keyboard),
    .oct_up  (oct_up),
    .oct_dn  (oct_dn),
    .note_on (note_on),
    .note_idx(note_idx),
    .scale   (scale),
    .ivalid  (ivalid),
    .idata   (idata),
    .iready  (iready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    if (got_q.size() != 0) obs = got_q.pop_front();
    else obs = 10'bx;
    check(tag, {22'd0, obs}, {22'd0, exp});
  endtask

  // Mid-cycle monitor: logs accepted words and checks that a stalled word
  // stays valid and unchanged until it is taken.
  always @(negedge clk) begin
    if (reset_n) begin
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold) begin
        check("stall ivalid", {31'd0, ivalid}, 32'd1);
        check("stall idata", {22'd0, idata}, {22'd0, prev_data});
      end
      if (ivalid && iready) got_q.push_back(idata);
      prev_hold <= ivalid && !iready;
      prev_data <= idata;
    end
  end

  initial begin
    reset_n  = 1'b0;
    keyboard = '0;
    oct_up   = 1'b0;
    oct_dn   = 1'b0;
    iready   = 1'b1;
    #2 reset_n = 1'b1;
    #1;
    check("rst note_on", {31'd0, note_on}, 32'd0);
    check("rst note_idx", {28'd0, note_idx}, 32'd0);
    check("rst scale", {29'd0, scale}, 32'd1);
    check("rst ivalid", {31'd0, ivalid}, 32'd0);
    check("rst idata", {22'd0, idata}, 32'd0);
    cycles(3);
    reset_n = 1'b0;

    // Single key 5 held for 10 ticks.
    keyboard[5] = 1'b1;
    cycles(10 * SampleDiv);
    check("k5 note_on", {31'd0, note_on}, 32'd1);
    check("k5 note_idx", {28'd0, note_idx}, 32'd5);
    keyboard[5] = 1'b0;
    cycles(Settle);
    check("k5 off", {31'd0, note_on}, 32'd0);
    pop_check("k5 press word", 10'h254);
    pop_check("k5 release word", 10'h054);
    check("k5 word count", got_q.size(), 32'd0);

    // Priority: newest press wins, fall back to held key.
    keyboard[2] = 1'b1;
    cycles(Settle);
    check("pri own2", {28'd0, note_idx}, 32'd2);
    keyboard[9] = 1'b1;
    cycles(Settle);
    check("pri own9", {28'd0, note_idx}, 32'd9);
    keyboard[9] = 1'b0;
    cycles(Settle);
    check("pri back2 on", {31'd0, note_on}, 32'd1);
    check("pri back2", {28'd0, note_idx}, 32'd2);
    keyboard[2] = 1'b0;
    cycles(Settle);
    check("pri none", {31'd0, note_on}, 32'd0);
    keyboard[4] = 1'b1;
    keyboard[7] = 1'b1;
    cycles(Settle);
    check("pri tie own4", {28'd0, note_idx}, 32'd4);
    keyboard[4] = 1'b0;
    keyboard[7] = 1'b0;
    cycles(Settle);
    pop_check("pri p2", 10'h248);
    pop_check("pri p9", 10'h264);
    pop_check("pri r9", 10'h064);
    pop_check("pri r2", 10'h048);
    pop_check("pri p4", 10'h250);
    pop_check("pri p7", 10'h25C);
    pop_check("pri r4", 10'h050);
    pop_check("pri r7", 10'h05C);
    check("pri word count", got_q.size(), 32'd0);

    // Bounce: level flips between every pair of tick samples, so two
    // consecutive samples never agree on the new level.
    for (int t = 0; t < 6; t++) begin
      keyboard[3] = (t % 2 == 0);
      cycles(SampleDiv);
    end
    keyboard[3] = 1'b0;
    cycles(Settle);
    check("bounce note_on", {31'd0, note_on}, 32'd0);
    check("bounce words", got_q.size(), 32'd0);

    // Scale stepping and saturation.
    for (int p = 0; p < 6; p++) begin
      oct_up = 1'b1;
      cycles(Settle);
      check("scale up", {29'd0, scale}, (p < 4) ? 32'(p + 2) : 32'd5);
      oct_up = 1'b0;
      cycles(Settle);
    end
    oct_up = 1'b1;
    oct_dn = 1'b1;
    cycles(Settle);
    check("scale both", {29'd0, scale}, 32'd5);
    oct_up = 1'b0;
    oct_dn = 1'b0;
    cycles(Settle);
    oct_dn = 1'b1;
    cycles(Settle);
    check("scale dn", {29'd0, scale}, 32'd4);
    oct_dn = 1'b0;
    cycles(Settle);
    oct_up = 1'b1;
    cycles(Settle);
    check("scale up again", {29'd0, scale}, 32'd5);
    oct_up = 1'b0;
    cycles(Settle);
    check("scale no words", got_q.size(), 32'd0);
    keyboard[0] = 1'b1;
    cycles(Settle);
    keyboard[0] = 1'b0;
    cycles(Settle);
    pop_check("s5 p0", 10'h340);
    pop_check("s5 r0", 10'h140);

    // Backpressure: three simultaneous presses behind a stalled FIFO.
    iready       = 1'b0;
    keyboard[1]  = 1'b1;
    keyboard[6]  = 1'b1;
    keyboard[12] = 1'b1;
    cycles(Settle);
    check("bp ivalid", {31'd0, ivalid}, 32'd1);
    check("bp first idata", {22'd0, idata}, 32'h344);
    check("bp owner", {28'd0, note_idx}, 32'd1);
    iready = 1'b1;
    cycles(Settle);
    pop_check("bp p1", 10'h344);
    pop_check("bp p6", 10'h358);
    pop_check("bp p12", 10'h370);
    check("bp word count", got_q.size(), 32'd0);

    // Reset while a release word is stalled in SEND.
    iready   = 1'b0;
    keyboard = '0;
    cycles(Settle);
    check("pre-rst ivalid", {31'd0, ivalid}, 32'd1);
    check("pre-rst idata", {22'd0, idata}, 32'h144);
    @(posedge clk);
    #3 reset_n = 1'b1;
    #1;
    check("mid rst ivalid", {31'd0, ivalid}, 32'd0);
    check("mid rst idata", {22'd0, idata}, 32'd0);
    check("mid rst note_on", {31'd0, note_on}, 32'd0);
    check("mid rst note_idx", {28'd0, note_idx}, 32'd0);
    check("mid rst scale", {29'd0, scale}, 32'd1);
    cycles(3);
    reset_n = 1'b0;
    iready  = 1'b1;
    cycles(Settle);
    check("post rst scale", {29'd0, scale}, 32'd1);
    check("post rst ivalid", {31'd0, ivalid}, 32'd0);
    check("post rst words", got_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
